// File: rtl/manchester_serializer_if.sv
// manchester_serializer_if: valid/ready word handshake into the serializer
//   in_data  : 16-bit encoded word, bit 15 sent first
//   in_valid : in_data is presented
//   in_ready : holding register empty (and serializer enabled)
interface manchester_serializer_if;
  logic [15:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master (output in_data, in_valid, input in_ready);
  modport slave (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/manchester_serializer.sv
// manchester_serializer: shifts 16-chip Manchester words onto a serial line, MSB first
//   clk, rst_n     : clock, asynchronous active-low reset
//   ena            : global enable, freezes all state when low
//   idle_level     : line level while no word is being sent
//   bus            : word handshake (in_data, in_valid, in_ready)
//   tx_out         : registered serial line
//   tx_active      : a word is being shifted
//   word_done      : one-cycle pulse after the final chip completes
module manchester_serializer #(
  parameter int HALF_BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic idle_level,
  manchester_serializer_if.slave bus,
  output logic tx_out,
  output logic tx_active,
  output logic word_done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, n_state;
  logic [15:0] hold_data, n_hold_data, sh, n_sh;
  logic hold_valid, n_hold_valid, n_tx, wd_q, n_wd;
  logic [3:0] chip_idx, n_idx;
  logic [7:0] cyc, n_cyc;
  logic last_cyc;
  assign bus.in_ready = ~hold_valid & ena;
  assign tx_active = state == SHIFT;
  // The pulse register freezes with everything else; gating keeps the output low while disabled.
  assign word_done = wd_q & ena;
  assign last_cyc = cyc == 8'(HALF_BIT_CYCLES - 1);
  always_comb begin
    n_state = state;
    n_hold_data = bus.in_valid & bus.in_ready ? bus.in_data : hold_data;
    n_hold_valid = hold_valid | (bus.in_valid & bus.in_ready);
    n_sh = sh;
    n_idx = chip_idx;
    n_cyc = cyc;
    n_tx = tx_out;
    n_wd = 1'b0;
    if (state == SHIFT) begin
      n_cyc = last_cyc ? 8'd0 : cyc + 8'd1;
      if (last_cyc && chip_idx != 4'd15) begin
        n_idx = chip_idx + 4'd1;
        n_sh = sh << 1;
        n_tx = sh[14];
      end else if (last_cyc) begin
        n_wd = 1'b1;
        n_state = IDLE;
        n_tx = idle_level;
      end
    end else begin
      n_tx = idle_level;
    end
    // Reload from the holding register: from IDLE, or seamlessly at the end of the last chip.
    // Acceptance cannot coincide with this since in_ready is low while hold_valid is set.
    if (hold_valid && (state == IDLE || (last_cyc && chip_idx == 4'd15))) begin
      n_state = SHIFT;
      n_sh = hold_data;
      n_tx = hold_data[15];
      n_idx = 4'd0;
      n_cyc = 8'd0;
      n_hold_valid = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold_data <= '0;
      hold_valid <= 1'b0;
      sh <= '0;
      chip_idx <= '0;
      cyc <= '0;
      tx_out <= 1'b0;
      wd_q <= 1'b0;
    end else if (ena) begin
      state <= n_state;
      hold_data <= n_hold_data;
      hold_valid <= n_hold_valid;
      sh <= n_sh;
      chip_idx <= n_idx;
      cyc <= n_cyc;
      tx_out <= n_tx;
      wd_q <= n_wd;
    end
  end
endmodule
